// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter sharing one I2C master between NREQ sensor sequencers,
// with owner-side routing of master status and a stall watchdog.
module i2c_master_arbiter #(
  parameter int          NREQ    = 4,
  parameter logic [15:0] TIMEOUT = 16'hFFFF,
  parameter int          HOLD    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  output logic [NREQ-1:0]      gnt,
  output logic                 busy,
  output logic                 timeout_err,
  output logic [2:0]           err_id,
  input  logic [NREQ-1:0]      m_start_i,
  input  logic [NREQ-1:0]      m_send_i,
  input  logic [NREQ-1:0]      m_receive_i,
  input  logic [8*NREQ-1:0]    m_datasend_i,
  output logic [NREQ-1:0]      r_isReady,
  output logic [NREQ-1:0]      r_sended,
  output logic [NREQ-1:0]      r_received,
  output logic [7:0]           r_datareceive,
  input  logic                 isReady,
  output logic                 start,
  output logic                 send,
  output logic                 receive,
  output logic [7:0]           datasend,
  input  logic                 sended,
  input  logic                 received,
  input  logic [7:0]           datareceive
);

  localparam int unsigned NREQU = NREQ;

  typedef enum logic [2:0] {StIdle, StArb, StOwn, StDrain, StHold} stateT;

  stateT             state, stateNext;
  logic [NREQ-1:0]   mask, elig, rot, pickOneHot;
  logic [2*NREQ-1:0] eligTwice;
  logic [2:0]        owner, last, pick;
  logic              pickValid;
  logic [15:0]       watchdog;
  logic [7:0]        holdCnt;
  logic              sendedQ, receivedQ, toggled, ownerReq, expired, holdDone;

  assign elig      = req & ~mask;
  assign eligTwice = {elig, elig};
  assign ownerReq  = |(req & gnt);
  assign toggled   = (sended != sendedQ) || (received != receivedQ);
  assign expired   = (watchdog == TIMEOUT);
  assign holdDone  = (holdCnt == 8'(HOLD - 1));
  assign busy      = (state != StIdle);

  // Rotate so the slot right after `last` sits at bit 0; the lowest set bit wins.
  always_comb begin
    int unsigned sum;
    sum       = 0;
    rot       = NREQ'(eligTwice >> (32'(last) + 32'd1));
    pick      = '0;
    pickValid = 1'b0;
    for (int unsigned i = 0; i < NREQU; i++) begin
      if (!pickValid && rot[i]) begin
        sum = 32'(last) + 32'd1 + i;
        if (sum >= NREQU) sum = sum - NREQU;
        pick      = 3'(sum);
        pickValid = 1'b1;
      end
    end
  end

  assign pickOneHot = {{(NREQ-1){1'b0}}, 1'b1} << pick;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= StIdle;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      StIdle:  if ((|elig) && isReady) stateNext = StArb;
      StArb:   stateNext = pickValid ? StOwn : StIdle;
      StOwn:   if (!ownerReq || expired) stateNext = StDrain;
      StDrain: if (isReady) stateNext = StHold;
      StHold:  if (holdDone) stateNext = StIdle;
      default: stateNext = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt         <= '0;
      owner       <= '0;
      last        <= 3'(NREQ - 1);
      mask        <= '0;
      watchdog    <= '0;
      holdCnt     <= '0;
      timeout_err <= 1'b0;
      err_id      <= '0;
      sendedQ     <= 1'b0;
      receivedQ   <= 1'b0;
    end else begin
      sendedQ     <= sended;
      receivedQ   <= received;
      timeout_err <= 1'b0;
      mask        <= mask & req;
      case (state)
        StArb: begin
          if (pickValid) begin
            gnt      <= pickOneHot;
            owner    <= pick;
            watchdog <= '0;
          end
        end
        StOwn: begin
          // A dropped request takes priority over a coincident watchdog expiry.
          if (!ownerReq) begin
            gnt <= '0;
          end else if (expired) begin
            gnt         <= '0;
            timeout_err <= 1'b1;
            err_id      <= owner;
            mask        <= (mask & req) | gnt;
          end else if (toggled) begin
            watchdog <= '0;
          end else if (watchdog != TIMEOUT) begin
            watchdog <= watchdog + 16'd1;
          end
        end
        StDrain: begin
          if (isReady) holdCnt <= '0;
        end
        StHold: begin
          holdCnt <= holdCnt + 8'd1;
          if (holdDone) last <= owner;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    start    = |(gnt & m_start_i);
    send     = |(gnt & m_send_i);
    receive  = |(gnt & m_receive_i);
    datasend = '0;
    for (int unsigned k = 0; k < NREQU; k++) begin
      if (gnt[k]) datasend = datasend | m_datasend_i[8*k +: 8];
    end
  end

  assign r_isReady     = gnt & {NREQ{isReady}};
  assign r_sended      = gnt & {NREQ{sended}};
  assign r_received    = gnt & {NREQ{received}};
  assign r_datareceive = datareceive;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Randomized bench for i2c_master_arbiter against a transaction-level model of
// round-robin ownership, masking after timeouts, and release/hold timing.
module tb_i2c_master_arbiter;

  localparam int NREQ  = 4;
  localparam int TMO   = 32;
  localparam int HOLDC = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req, gnt;
  logic              busy, timeout_err;
  logic [2:0]        err_id;
  logic [NREQ-1:0]   m_start_i, m_send_i, m_receive_i;
  logic [8*NREQ-1:0] m_datasend_i;
  logic [NREQ-1:0]   r_isReady, r_sended, r_received;
  logic [7:0]        r_datareceive;
  logic              isReady, start, send, receive;
  logic [7:0]        datasend;
  logic              sended, received;
  logic [7:0]        datareceive;

  always #5 clk = ~clk;

  i2c_master_arbiter #(.NREQ(NREQ), .TIMEOUT(16'(TMO)), .HOLD(HOLDC)) dut (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt), .busy(busy),
    .timeout_err(timeout_err), .err_id(err_id),
    .m_start_i(m_start_i), .m_send_i(m_send_i), .m_receive_i(m_receive_i),
    .m_datasend_i(m_datasend_i),
    .r_isReady(r_isReady), .r_sended(r_sended), .r_received(r_received),
    .r_datareceive(r_datareceive),
    .isReady(isReady), .start(start), .send(send), .receive(receive),
    .datasend(datasend), .sended(sended), .received(received),
    .datareceive(datareceive)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  int              lastOwner;
  logic [NREQ-1:0] maskM;
  int              errIdM;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int expWinner();
    for (int i = 1; i <= NREQ; i++) begin
      int k;
      k = (lastOwner + i) % NREQ;
      if (req[k] && !maskM[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [31:0] oneHot(input int k);
    return (k >= 0) ? (32'd1 << k) : 32'd0;
  endfunction

  task automatic randomizeSide();
    m_start_i    = NREQ'($urandom);
    m_send_i     = NREQ'($urandom);
    m_receive_i  = NREQ'($urandom);
    m_datasend_i = $urandom;
    datareceive  = 8'($urandom);
  endtask

  task automatic checkOwnerPaths(input int own);
    checkEq("gntOwn",    gnt, oneHot(own));
    checkEq("busyOwn",   busy, 1);
    checkEq("start",     start, m_start_i[own]);
    checkEq("send",      send, m_send_i[own]);
    checkEq("receive",   receive, m_receive_i[own]);
    checkEq("datasend",  datasend, m_datasend_i[8*own +: 8]);
    checkEq("rIsReady",  r_isReady, isReady ? oneHot(own) : 0);
    checkEq("rSended",   r_sended, sended ? oneHot(own) : 0);
    checkEq("rReceived", r_received, received ? oneHot(own) : 0);
    checkEq("rDataRx",   r_datareceive, datareceive);
  endtask

  task automatic checkQuiet(input string tag);
    checkEq({tag, "Gnt"}, gnt, 0);
    checkEq({tag, "Master"}, {start, send, receive, datasend}, 0);
    checkEq({tag, "Route"}, {r_isReady, r_sended, r_received}, 0);
  endtask

  // From the idle sample: one edge to arbitrate, one edge to register the grant.
  task automatic waitGrant(output int own);
    int n;
    own = expWinner();
    n = 0;
    while (gnt == 0 && n < 40) begin
      tick();
      n++;
    end
    checkEq("grantLat", n, 2);
    checkEq("grant", gnt, oneHot(own));
    if (own >= 0) lastOwner = own;
  endtask

  task automatic ownNormal(input int own);
    int len;
    len = $urandom_range(2, 8);
    repeat (len) begin
      randomizeSide();
      isReady = 1'($urandom);
      if ($urandom_range(0, 1) == 1) sended = ~sended;
      if ($urandom_range(0, 2) == 0) received = ~received;
      #1;
      checkOwnerPaths(own);
      tick();
    end
  endtask

  // Owner never toggles; with race set it drops req on the last cycle before expiry.
  task automatic ownStall(input int own, input bit race, output bit raced);
    int cnt;
    raced   = 1'b0;
    isReady = 1'b1;
    cnt     = 1;
    while (gnt != 0 && cnt < 200) begin
      randomizeSide();
      #1;
      checkEq("stallData", datasend, m_datasend_i[8*own +: 8]);
      if (race && cnt == TMO + 1) begin
        req[own] = 1'b0;
        raced = 1'b1;
        break;
      end
      tick();
      if (gnt != 0) cnt++;
    end
    if (!raced) begin
      checkEq("stallLen", cnt, TMO + 1);
      checkEq("toErr", timeout_err, 1);
      checkEq("errId", err_id, own);
      maskM[own] = 1'b1;
      errIdM = own;
    end
  endtask

  // Release: one edge to leave ownership, DRAIN until isReady is seen, then HOLD quiet edges.
  task automatic releaseAndSetup(input int own, input bit timedOut);
    int s, n, raiseAt, raiseBit, expLen;
    logic [NREQ-1:0] dropped;
    dropped = '0;
    if (timedOut) begin
      s = 0;
      n = 1;
      isReady = 1'b1;
    end else begin
      s = $urandom_range(0, 3);
      n = 0;
      req[own] = 1'b0;
      dropped[own] = 1'b1;
      isReady = (s == 0);
    end
    for (int k = 0; k < NREQ; k++) begin
      if (maskM[k] && req[k] && $urandom_range(0, 1) == 1) begin
        req[k] = 1'b0; maskM[k] = 1'b0; dropped[k] = 1'b1;
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      if (!req[k] && !dropped[k] && $urandom_range(0, 2) == 0) req[k] = 1'b1;
    end
    raiseBit = -1;
    if ((req & ~maskM) == 0) begin
      for (int k = 0; k < NREQ; k++) begin
        if (maskM[k] && req[k]) begin
          req[k] = 1'b0; maskM[k] = 1'b0; dropped[k] = 1'b1;
        end
      end
      do raiseBit = $urandom_range(0, NREQ - 1); while (!dropped[raiseBit]);
    end
    raiseAt = n + 2;
    expLen  = 1 + (s + 1) + HOLDC;
    while (busy && n < 40) begin
      tick();
      n++;
      checkQuiet("drain");
      checkEq("toErrQuiet", timeout_err, 0);
      checkEq("errIdHeld", err_id, errIdM);
      if (n == s + 1) isReady = 1'b1;
      if (n == raiseAt && raiseBit >= 0) req[raiseBit] = 1'b1;
    end
    checkEq("holdLen", n, expLen);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL globalTimeout: got no finish, expected finish by 2ms");
    $fatal(1);
  end

  initial begin
    int own;
    bit raced;
    reset = 1'b0; req = '0; isReady = 1'b1;
    m_start_i = '1; m_send_i = '1; m_receive_i = '1; m_datasend_i = '1;
    sended = 1'b0; received = 1'b0; datareceive = 8'h00;
    repeat (3) tick();
    checkEq("rstGnt", gnt, 0);
    checkEq("rstBusy", busy, 0);
    checkEq("rstToErr", timeout_err, 0);
    checkEq("rstErrId", err_id, 0);
    checkQuiet("rst");

    reset = 1'b1;
    lastOwner = NREQ - 1; maskM = '0; errIdM = 0;

    // Not ready in IDLE: request waits, then two edges to grant.
    isReady = 1'b0;
    req = 4'b0001;
    repeat (4) begin
      tick();
      checkEq("notReadyGnt", gnt, 0);
      checkEq("notReadyBusy", busy, 0);
    end
    isReady = 1'b1;
    tick();
    checkEq("arbGnt", gnt, 0);
    tick();
    checkEq("firstGnt", gnt, 4'b0001);
    lastOwner = 0;
    ownNormal(0);
    releaseAndSetup(0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      int kind;
      waitGrant(own);
      if (own < 0) own = 0;
      kind = (t % 7 == 3) ? 1 : (t % 11 == 5) ? 2 : ($urandom_range(0, 5) == 0 ? 1 : 0);
      if (kind == 0) begin
        ownNormal(own);
        releaseAndSetup(own, 1'b0);
      end else begin
        ownStall(own, kind == 2, raced);
        releaseAndSetup(own, !raced);
      end
    end

    // Asynchronous reset in the middle of an ownership.
    waitGrant(own);
    if (own < 0) own = 0;
    m_start_i = '0;
    m_start_i[own] = 1'b1;
    #1;
    checkEq("startOn", start, 1);
    #2;
    reset = 1'b0;
    #1;
    checkEq("asyncGnt", gnt, 0);
    checkEq("asyncStart", start, 0);
    checkEq("asyncBusy", busy, 0);
    checkEq("asyncErrId", err_id, 0);
    tick();
    tick();
    reset = 1'b1;
    lastOwner = NREQ - 1; maskM = '0; errIdM = 0;
    req = '1;
    isReady = 1'b1;
    tick();
    checkEq("postRstArb", gnt, 0);
    tick();
    checkEq("postRstGnt", gnt, 4'b0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
